// File: rtl/deal_pkg.sv
// Shared types and default constants for the dealer stage and its bitmap.
package deal_pkg;

  localparam int N_DEF       = 3;
  localparam int STIR_DEF    = 5;
  localparam int MAX_TRY_DEF = 64;
  localparam int TW_DEF      = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_STIR  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/deal_used_map.sv
// One flag per reachable value: clear-all, set-one, combinational read-one.
module deal_used_map #(
  parameter int N = 3
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_fClr,
  input  logic         i_fSet,
  input  logic [N-1:0] i_SetIdx,
  input  logic [N-1:0] i_RdIdx,
  output logic         o_fUsed
);

  logic [2**N-1:0] used_q;
  logic [2**N-1:0] used_d;

  for (genvar gi = 0; gi < 2**N; gi++) begin : g_bit
    assign used_d[gi] = i_fClr ? 1'b0
                      : (used_q[gi] | (i_fSet && (i_SetIdx == N'(gi))));
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) used_q <= '0;
    else        used_q <= used_d;
  end

  assign o_fUsed = used_q[i_RdIdx];

endmodule

// File: rtl/deal_ctrl.sv
// Draw-without-replacement dealer: drives the generator's shuffle/stop
// handshake and streams i_Count distinct values below i_Max.
module deal_ctrl
  import deal_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int STIR    = STIR_DEF,
  parameter int MAX_TRY = MAX_TRY_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_fStart,
  input  logic [N-1:0] i_Max,
  input  logic [N-1:0] i_Count,
  output logic         o_fShuffle,
  output logic         o_fStop,
  input  logic         i_fRdy,
  input  logic [N-1:0] i_Num,
  output logic         o_fVld,
  output logic [N-1:0] o_Val,
  output logic         o_fBusy,
  output logic         o_fDone,
  output logic         o_fErr
);

  state_e        state_q, state_d;
  logic [7:0]    stir_q, stir_d;
  logic [N-1:0]  max_q, max_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  num_q, num_d;
  logic [N-1:0]  deal_q, deal_d;
  logic [N-1:0]  val_q, val_d;
  logic [TW-1:0] try_q, try_d;
  logic          err_q, err_d;
  logic          map_clr, map_set, num_used;
  logic [N-1:0]  deal_inc;
  logic [TW-1:0] try_inc;

  assign deal_inc = deal_q + N'(1);
  assign try_inc  = try_q + TW'(1);

  deal_used_map #(.N(N)) u_used_map (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_fClr   (map_clr),
    .i_fSet   (map_set),
    .i_SetIdx (num_q),
    .i_RdIdx  (num_q),
    .o_fUsed  (num_used)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q <= S_IDLE;
      stir_q  <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      deal_q  <= '0;
      val_q   <= '0;
      try_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stir_q  <= stir_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      deal_q  <= deal_d;
      val_q   <= val_d;
      try_q   <= try_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stir_d     = stir_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    deal_d     = deal_q;
    val_d      = val_q;
    try_d      = try_q;
    err_d      = err_q;
    map_clr    = 1'b0;
    map_set    = 1'b0;
    o_fShuffle = 1'b0;
    o_fStop    = 1'b0;
    o_fVld     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_fStart) begin
          max_d   = i_Max;
          cnt_d   = i_Count;
          deal_d  = '0;
          try_d   = '0;
          err_d   = 1'b0;
          map_clr = 1'b1;
          state_d = (i_Count == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        o_fShuffle = 1'b1;
        stir_d     = 8'(STIR - 1);
        state_d    = S_STIR;
      end
      S_STIR: begin
        if (stir_q == '0) begin
          o_fStop = 1'b1;
          state_d = S_WAIT;
        end else begin
          stir_d = stir_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (i_fRdy) begin
          num_d   = i_Num;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((num_q < max_q) && !num_used) begin
          o_fVld  = 1'b1;
          map_set = 1'b1;
          val_d   = num_q;
          deal_d  = deal_inc;
          try_d   = '0;
          state_d = (deal_inc == cnt_q) ? S_DONE : S_REQ;
        end else begin
          try_d = try_inc;
          // A count the generator cannot satisfy also ends here.
          if (try_inc == TW'(MAX_TRY)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The value is visible in the same cycle as its o_fVld pulse.
  assign o_Val   = o_fVld ? num_q : val_q;
  assign o_fBusy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_fDone = (state_q == S_DONE);
  assign o_fErr  = err_q;

endmodule

// File: tb/tb_deal_ctrl.sv
// Directed bench for deal_ctrl: plays the generator, scoreboards dealt values.
module tb_deal_ctrl;

  localparam int N       = 3;
  localparam int STIR    = 5;
  localparam int MAX_TRY = 64;
  localparam int TW      = 7;

  logic         clk = 1'b0;
  logic         i_Rst, i_fStart, i_fRdy;
  logic [N-1:0] i_Max, i_Count, i_Num;
  logic         o_fShuffle, o_fStop, o_fVld, o_fBusy, o_fDone, o_fErr;
  logic [N-1:0] o_Val;

  int pass_cnt    = 0;
  int total_cnt   = 0;
  int shuf_cnt    = 0;
  int overlap_cnt = 0;
  logic [N-1:0] exp_q[$];

  deal_ctrl #(.N(N), .STIR(STIR), .MAX_TRY(MAX_TRY), .TW(TW)) dut (
    .i_Clk      (clk),
    .i_Rst      (i_Rst),
    .i_fStart   (i_fStart),
    .i_Max      (i_Max),
    .i_Count    (i_Count),
    .o_fShuffle (o_fShuffle),
    .o_fStop    (o_fStop),
    .i_fRdy     (i_fRdy),
    .i_Num      (i_Num),
    .o_fVld     (o_fVld),
    .o_Val      (o_Val),
    .o_fBusy    (o_fBusy),
    .o_fDone    (o_fDone),
    .o_fErr     (o_fErr)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Output monitor: pops the scoreboard on every o_fVld pulse.
  always @(negedge clk) begin
    if (o_fShuffle) shuf_cnt++;
    if (o_fShuffle && o_fStop) overlap_cnt++;
    if (o_fVld) begin
      if (exp_q.size() == 0) chk("unexpected_vld", 32'(o_fVld), 32'd0);
      else                   chk("dealt_value", 32'(o_Val), 32'(exp_q.pop_front()));
    end
  end

  task automatic start(input logic [N-1:0] m, input logic [N-1:0] c);
    i_Max    = m;
    i_Count  = c;
    i_fStart = 1'b1;
    @(negedge clk);
    i_fStart = 1'b0;
  endtask

  // One generator round trip: wait for shuffle, time the stop, answer after dly cycles.
  task automatic draw(input logic [N-1:0] v, input bit acc, input int dly, input bit poke);
    int n = 0;
    int pulses = 0;
    int busy_lo = 0;
    while (!o_fShuffle && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("shuffle_seen", 32'(o_fShuffle), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (poke && n == 2) begin
        i_fStart = 1'b1;
        i_Count  = 3'd0;
        i_Max    = 3'd1;
      end else if (poke && n == 3) begin
        i_fStart = 1'b0;
      end
    end while (!o_fStop && n < 20);
    chk("stir_gap", 32'(n), 32'(STIR));
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      pulses += int'(o_fShuffle) + int'(o_fStop) + int'(o_fVld);
      if (!o_fBusy) busy_lo++;
    end
    chk("wait_quiet", 32'(pulses + busy_lo), 32'd0);
    if (acc) exp_q.push_back(v);
    i_Num  = v;
    i_fRdy = 1'b1;
    @(negedge clk);
    i_fRdy = 1'b0;
    chk("vld_flag", 32'(o_fVld), 32'(acc));
  endtask

  initial begin
    int s0;
    int n;
    i_Rst = 1'b0; i_fStart = 1'b0; i_fRdy = 1'b0;
    i_Max = '0; i_Count = '0; i_Num = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({o_fShuffle, o_fStop, o_fVld, o_Val, o_fBusy, o_fDone, o_fErr}), 32'd0);
    i_Rst = 1'b1;
    @(negedge clk);

    // Zero count from IDLE: done next cycle, no shuffle.
    chk("idle_not_done", 32'(o_fDone), 32'd0);
    s0 = shuf_cnt;
    start(3'd6, 3'd0);
    chk("zero_count_done", 32'(o_fDone), 32'd1);
    repeat (5) @(negedge clk);
    chk("zero_count_no_shuffle", 32'(shuf_cnt - s0), 32'd0);
    chk("zero_count_idle", 32'({o_fBusy, o_fErr}), 32'd0);

    // Main deal with the 1,3,7,6,5,2,4 generator cycle.
    start(3'd6, 3'd5);
    chk("start_to_shuffle", 32'(o_fShuffle), 32'd1);
    chk("start_clears_done", 32'(o_fDone), 32'd0);
    draw(3'd1, 1'b1, 10, 1'b0);
    draw(3'd3, 1'b1, 1, 1'b0);
    draw(3'd7, 1'b0, 1, 1'b0);
    draw(3'd6, 1'b0, 2, 1'b0);
    draw(3'd5, 1'b1, 1, 1'b0);
    draw(3'd2, 1'b1, 1, 1'b0);
    draw(3'd4, 1'b1, 3, 1'b0);
    @(negedge clk);
    chk("deal_done", 32'({o_fDone, o_fErr, o_fBusy}), 32'b100);
    chk("hold_last_val", 32'(o_Val), 32'd4);

    // Stuck generator: one accept then MAX_TRY rejects.
    start(3'd6, 3'd2);
    draw(3'd3, 1'b1, 1, 1'b0);
    for (int i = 0; i < MAX_TRY; i++) draw(3'd3, 1'b0, 1, 1'b0);
    @(negedge clk);
    chk("abort_err_done", 32'({o_fDone, o_fErr, o_fBusy}), 32'b110);

    // Restart clears error and bitmap; a start during STIR is ignored.
    start(3'd6, 3'd2);
    chk("restart_clears_err", 32'(o_fErr), 32'd0);
    draw(3'd3, 1'b1, 1, 1'b1);
    draw(3'd5, 1'b1, 1, 1'b0);
    @(negedge clk);
    chk("restart_done", 32'({o_fDone, o_fErr, o_fBusy}), 32'b100);

    // Reset in the middle of WAIT abandons the sequence.
    start(3'd6, 3'd2);
    n = 0;
    while (!o_fStop && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stop_seen", 32'(o_fStop), 32'd1);
    @(negedge clk);
    i_Rst = 1'b0;
    @(negedge clk);
    i_Rst = 1'b1;
    chk("midreset_outputs",
        32'({o_fShuffle, o_fStop, o_fVld, o_Val, o_fBusy, o_fDone, o_fErr}), 32'd0);
    i_Num  = 3'd2;
    i_fRdy = 1'b1;
    @(negedge clk);
    i_fRdy = 1'b0;
    chk("midreset_no_vld", 32'(o_fVld), 32'd0);
    @(negedge clk);
    chk("midreset_idle", 32'({o_fVld, o_fBusy, o_fDone}), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("shuffle_stop_overlap", 32'(overlap_cnt), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
